// File: rtl/comparador_serial_if.sv
// comparador_serial_if: handshake and flag bundle between the 1-bit comparator stage and the serial word comparator
interface comparador_serial_if;
    logic inicio, valido, Amaior_in, igual_in, Amenor_in;
    logic Amaior, igual, Amenor, erro, pronto, ocupado;
    modport master (
        output inicio, valido, Amaior_in, igual_in, Amenor_in,
        input  Amaior, igual, Amenor, erro, pronto, ocupado
    );
    modport slave (
        input  inicio, valido, Amaior_in, igual_in, Amenor_in,
        output Amaior, igual, Amenor, erro, pronto, ocupado
    );
endinterface

// File: rtl/comparador_serial.sv
// comparador_serial: MSB-first serial N-bit magnitude comparator fed by per-bit one-hot flags
module comparador_serial #(
    parameter int N = 8
) (
    input logic clk,
    input logic rst_n,
    comparador_serial_if.slave bus
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {OCIOSO, COMPARANDO, PRONTO} estado_t;
    typedef enum logic [1:0] {EQ, GT, LT} decisao_t;
    estado_t estado, prox;
    decisao_t dec, dec_nx;
    logic [CW-1:0] cnt;
    logic err, err_nx, um_quente, inicia, aceita, ultimo;
    logic res_gt, res_eq, res_lt, res_err, pronto, ocupado;
    // handshake decode and per-bit decision; the decision only moves while still EQ
    always_comb begin
        um_quente = $onehot({bus.Amaior_in, bus.igual_in, bus.Amenor_in});
        inicia = (estado == OCIOSO || estado == PRONTO) && bus.inicio;
        aceita = estado == COMPARANDO && bus.valido;
        ultimo = aceita && cnt == CW'(N - 1);
        dec_nx = (dec == EQ && um_quente) ? (bus.Amaior_in ? GT : bus.Amenor_in ? LT : EQ) : dec;
        err_nx = err | ~um_quente;
    end
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= OCIOSO;
        else estado <= prox;
    end
    // next state: start wins in OCIOSO/PRONTO, the Nth accepted bit ends the word
    always_comb begin
        prox = inicia ? COMPARANDO : ultimo ? PRONTO : estado == COMPARANDO ? COMPARANDO : OCIOSO;
    end
    // bit counter, running decision/error, and result registers loaded on the last bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dec <= EQ;
            err <= 1'b0;
            res_gt <= 1'b0;
            res_eq <= 1'b0;
            res_lt <= 1'b0;
            res_err <= 1'b0;
        end else if (inicia) begin
            cnt <= '0;
            dec <= EQ;
            err <= 1'b0;
        end else if (aceita) begin
            cnt <= cnt + 1'b1;
            dec <= dec_nx;
            err <= err_nx;
            if (ultimo) begin
                res_gt <= !err_nx && dec_nx == GT;
                res_eq <= !err_nx && dec_nx == EQ;
                res_lt <= !err_nx && dec_nx == LT;
                res_err <= err_nx;
            end
        end
    end
    // status outputs are pure decodes of the state flops
    always_comb begin
        pronto = estado == PRONTO;
        ocupado = estado == COMPARANDO;
    end
    assign bus.Amaior = res_gt;
    assign bus.igual = res_eq;
    assign bus.Amenor = res_lt;
    assign bus.erro = res_err;
    assign bus.pronto = pronto;
    assign bus.ocupado = ocupado;
endmodule

// File: tb/tb_comparador_serial.sv
// tb_comparador_serial: directed checks of the serial comparator, inputs driven and outputs sampled on the falling edge
module tb_comparador_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int passed = 0;
    int failed = 0;
    int total = 0;
    int oc, early;
    logic [3:0] r0;
    comparador_serial_if bus ();
    comparador_serial #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    function automatic logic [3:0] res();
        return {bus.erro, bus.Amaior, bus.igual, bus.Amenor};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask
    task automatic drive(input logic ini, input logic val, input logic gt, input logic eq, input logic lt);
        bus.inicio = ini;
        bus.valido = val;
        bus.Amaior_in = gt;
        bus.igual_in = eq;
        bus.Amenor_in = lt;
        @(negedge clk);
    endtask
    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] stall,
                        input logic [7:0] bad, input logic [7:0] midini, input logic first_val,
                        output int ocup, output int prem, output logic [3:0] res_start);
        ocup = 0;
        prem = 0;
        drive(1'b1, first_val, 1'b0, 1'b0, first_val);
        res_start = res();
        ocup += int'(bus.ocupado);
        prem += int'(bus.pronto);
        for (int i = 7; i >= 0; i--) begin
            if (stall[i]) begin
                drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
                ocup += int'(bus.ocupado);
                prem += int'(bus.pronto);
            end
            drive(midini[i], 1'b1, bad[i] | (a[i] & ~b[i]), ~bad[i] & (a[i] == b[i]), bad[i] | (~a[i] & b[i]));
            ocup += int'(bus.ocupado);
            if (i > 0) prem += int'(bus.pronto);
        end
    endtask
    initial begin
        idle();
        idle();
        chk("reset_results", res(), 4'b0000);
        chk("reset_status", {bus.pronto, bus.ocupado}, 2'b00);
        rst_n = 1'b1;
        idle();
        send(8'hA5, 8'hA4, 8'h00, 8'h00, 8'h00, 1'b0, oc, early, r0);
        chk("basic_pronto", bus.pronto, 1'b1);
        chk("basic_early_pronto", early, 0);
        chk("basic_ocupado_cycles", oc, 8);
        chk("basic_result", res(), 4'b0100);
        chk("basic_ocupado_end", bus.ocupado, 1'b0);
        idle();
        chk("basic_idle_status", {bus.pronto, bus.ocupado}, 2'b00);
        chk("basic_hold", res(), 4'b0100);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_busy", bus.ocupado, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_results", res(), 4'b0000);
        chk("rst_mid_status", {bus.pronto, bus.ocupado}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst_mid_ocioso", {bus.pronto, bus.ocupado}, 2'b00);
        send(8'h3C, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0, oc, early, r0);
        chk("rst_after_pronto", bus.pronto, 1'b1);
        chk("rst_after_result", res(), 4'b0010);
        idle();
        send(8'h10, 8'h8F, 8'h48, 8'h00, 8'h00, 1'b0, oc, early, r0);
        chk("freeze_pronto", bus.pronto, 1'b1);
        chk("freeze_early_pronto", early, 0);
        chk("freeze_ocupado_cycles", oc, 10);
        chk("freeze_result", res(), 4'b0001);
        idle();
        send(8'h5A, 8'h5A, 8'h00, 8'h20, 8'h00, 1'b0, oc, early, r0);
        chk("bad_pronto", bus.pronto, 1'b1);
        chk("bad_result", res(), 4'b1000);
        idle();
        send(8'h5A, 8'h5A, 8'h00, 8'h00, 8'h00, 1'b0, oc, early, r0);
        chk("clean_hold_at_start", r0, 4'b1000);
        chk("clean_result", res(), 4'b0010);
        idle();
        send(8'h66, 8'h65, 8'h00, 8'h00, 8'h10, 1'b1, oc, early, r0);
        chk("ignored_early_pronto", early, 0);
        chk("ignored_pronto", bus.pronto, 1'b1);
        chk("ignored_result", res(), 4'b0100);
        idle();
        send(8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 1'b0, oc, early, r0);
        chk("b2b_w1_pronto", bus.pronto, 1'b1);
        chk("b2b_w1_result", res(), 4'b0001);
        send(8'h77, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, oc, early, r0);
        chk("b2b_hold_at_start", r0, 4'b0001);
        chk("b2b_ocupado_cycles", oc, 8);
        chk("b2b_w2_pronto", bus.pronto, 1'b1);
        chk("b2b_w2_result", res(), 4'b0010);
        idle();
        chk("b2b_pulse_end", {bus.pronto, bus.ocupado}, 2'b00);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/comparador_serial.md
# comparador_serial

- N-bit magnitude comparator that works serially, MSB first.
- Directly downstream of the 1-bit comparator: each cycle it consumes that stage's `Amaior`/`igual`/`Amenor` flags for one bit pair of operands A and B.
- It accumulates the word-level decision over N accepted bits and presents a registered A>B / A=B / A<B result with a one-cycle completion pulse.
- It also flags malformed input, where the per-bit flags are not one-hot.

## Interface

- `N`, default 8: operand width in bits; number of bit pairs consumed per comparison (N ≥ 1).
- `clk` input 1: single clock, rising-edge active.
- `rst_n` input 1: asynchronous, active-low reset.
- `inicio` input 1: starts a comparison; sampled in OCIOSO and PRONTO only.
- `valido` input 1: the bit flags on this cycle are valid; sampled in COMPARANDO only.
- `Amaior_in` input 1: per-bit A>B flag from the 1-bit comparator.
- `igual_in` input 1: per-bit A=B flag from the 1-bit comparator.
- `Amenor_in` input 1: per-bit A<B flag from the 1-bit comparator.
- `Amaior` output 1: registered word result, A>B.
- `igual` output 1: registered word result, A=B.
- `Amenor` output 1: registered word result, A<B.
- `erro` output 1: registered; at least one accepted bit had non-one-hot flags.
- `pronto` output 1: one-cycle pulse; the result outputs were updated this cycle.
- `ocupado` output 1: high while in COMPARANDO.

## Operation

**States**
- OCIOSO: reset state.
- COMPARANDO: accepting bit pairs.
- PRONTO: one cycle, result just published.

**Transitions**
- OCIOSO, `inicio`=1 → COMPARANDO. Clears bit counter (`$clog2(N+1)` bits), internal decision to EQ, internal error to 0.
- COMPARANDO, `valido`=1 → bit accepted, counter increments. On the Nth accepted bit → PRONTO.
- COMPARANDO, `valido`=0 → stall; no change.
- PRONTO, `inicio`=1 → COMPARANDO (back-to-back start, same clearing as above).
- PRONTO, `inicio`=0 → OCIOSO.

**Decision rule per accepted bit**
- Decision changes only while the internal decision is EQ. Once GT or LT, it is frozen for the rest of the word (MSB-first semantics).
- Remaining bits are still consumed and counted.
- While EQ:
  - `Amaior_in` alone → GT.
  - `Amenor_in` alone → LT.
  - `igual_in` alone → EQ.
- Flags not exactly one-hot (none set, or several set):
  - Sets internal error.
  - Does not change the decision.
  - Checked on every accepted bit, including after the decision is frozen.

**Result publication**
- At the edge accepting the Nth bit, output registers load:
  - `Amaior` = GT, `igual` = EQ, `Amenor` = LT, `erro` = internal error, including this bit's contribution.
  - If error, all three result outputs load 0 and `erro` = 1.
- Result outputs and `erro` hold until the next publication or reset. They are not cleared by `inicio`.

**Ignored inputs**
- `inicio` during COMPARANDO.
- `valido` during OCIOSO and PRONTO, including `valido` coincident with `inicio`; that bit is not consumed.

**Reset**
- `rst_n`=0 at any time, including mid-word, immediately forces:
  - state OCIOSO, counter 0;
  - `Amaior`=0, `igual`=0, `Amenor`=0, `erro`=0, `pronto`=0, `ocupado`=0.
- A partial word is discarded.

## Timing

- `inicio` sampled at edge e0 → `ocupado`=1 after e0.
- With `valido` held high, bits are accepted at edges e1..eN.
- After eN:
  - `pronto`=1 for exactly one cycle.
  - Results are valid; `ocupado`=0.
- Latency from `inicio` edge to `pronto`: N+1 edges minimum. Each stall cycle adds one.
- The combinational inputs from the 1-bit comparator must be stable at the accepting edge. There is no input registering, so there is no extra latency.
- Back-to-back: `inicio` high in the PRONTO cycle gives zero idle cycles between words.
- `ocupado` is a decode of state COMPARANDO, registered through the state flops.
- `pronto` is high iff state is PRONTO.
- All outputs are glitch-free registered values.

## Test plan

1. Reset mid-word:
   - Stimulus: N=8, start, accept 3 bits (GT at bit 2), assert `rst_n`=0 asynchronously between edges.
   - Required: all outputs 0 immediately; state OCIOSO.
   - Then a new word A=B=8'h3C gives `igual`=1.
2. Basic compare, no stalls:
   - Stimulus: N=8, A=8'hA5, B=8'hA4 driven MSB-first, `valido` constant high.
   - Required: `pronto` at edge 9 after `inicio`; `Amaior`=1, `igual`=0, `Amenor`=0, `erro`=0.
3. Freeze on MSB difference, with stalls:
   - Stimulus: A=8'h10, B=8'h8F (MSB gives LT, lower bits give GT); `valido` low on 2 arbitrary cycles.
   - Required: `Amenor`=1 only; `pronto` at edge 11; `ocupado` high for 10 cycles.
4. Malformed flags:
   - Stimulus: inject `Amaior_in`=`Amenor_in`=1 at bit 5 of an otherwise equal word.
   - Required: at publication `erro`=1 and `Amaior`=`igual`=`Amenor`=0.
   - Next clean equal word: `erro`=0, `igual`=1.
5. Ignored handshakes:
   - Stimulus: `valido` high with `inicio` in OCIOSO; `inicio` pulsed mid-word.
   - Required: the coincident bit is not counted; the mid-word start has no effect; `pronto` still after exactly N accepted bits.
6. Back-to-back words:
   - Stimulus: `inicio` high during PRONTO; word 1 A<B, word 2 A=B.
   - Required: no OCIOSO cycle between words; results change only at the second `pronto`, from `Amenor`=1 to `igual`=1.
